// File: rtl/seg7_scan.sv
// Four-digit common-anode scanner with guard band and registered active-low outputs.
// Define LEAD_ZERO_BLANK_EN to suppress leading zeros in the hundreds and tens slots.
module seg7_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd,
  input  logic [3:0] ge,
  input  logic [3:0] shi,
  input  logic [3:0] bai,
  input  logic [3:0] tag,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    snap_ge_q, snap_ge_d;
  logic [3:0]    snap_shi_q, snap_shi_d;
  logic [3:0]    snap_bai_q, snap_bai_d;
  logic [3:0]    snap_tag_q, snap_tag_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic       tick;
  logic       in_guard;
  logic       blank_digit;
  logic [3:0] cur_digit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  always_comb begin
    tick     = (pcnt_q == PW'(SCAN_DIV - 1));
    in_guard = (pcnt_q < PW'(GUARD));

    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;

    snap_ge_d  = snap_ge_q;
    snap_shi_d = snap_shi_q;
    snap_bai_d = snap_bai_q;
    snap_tag_d = snap_tag_q;
    if (upd) begin
      snap_ge_d  = ge;
      snap_shi_d = shi;
      snap_bai_d = bai;
      snap_tag_d = tag;
    end

    case (idx_q)
      2'd0:    cur_digit = snap_ge_q;
      2'd1:    cur_digit = snap_shi_q;
      2'd2:    cur_digit = snap_bai_q;
      default: cur_digit = snap_tag_q;
    endcase

`ifdef LEAD_ZERO_BLANK_EN
    blank_digit = ((idx_q == 2'd2) && (snap_bai_q == 4'd0)) ||
                  ((idx_q == 2'd1) && (snap_bai_q == 4'd0) && (snap_shi_q == 4'd0));
`else
    blank_digit = 1'b0;
`endif

    an_d  = 4'b1111;
    seg_d = 7'h7F;
    if (!in_guard && !blank_digit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt_q     <= '0;
      idx_q      <= 2'd0;
      snap_ge_q  <= 4'd0;
      snap_shi_q <= 4'd0;
      snap_bai_q <= 4'd0;
      snap_tag_q <= 4'd0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      snap_ge_q  <= snap_ge_d;
      snap_shi_q <= snap_shi_d;
      snap_bai_q <= snap_bai_d;
      snap_tag_q <= snap_tag_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed steps plus random digits against a time-based display model.
module tb_seg7_scan;
  localparam int DIV = 8;
  localparam int GRD = 2;

  logic       clk = 1'b0;
  logic       reset, upd;
  logic [3:0] ge, shi, bai, tag;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release and the captured digits (0=ge .. 3=tag)
  int         cyc;
  logic [3:0] snap [4];
  logic [6:0] glyph_tab [16];

  seg7_scan #(.SCAN_DIV(DIV), .GUARD(GRD)) dut (
    .clk(clk), .reset(reset), .upd(upd),
    .ge(ge), .shi(shi), .bai(bai), .tag(tag),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic model_out(output logic [3:0] ea, output logic [6:0] es);
    int  p, slot;
    bit  blank;
    p    = cyc % DIV;
    slot = (cyc / DIV) % 4;
    ea   = 4'b1111;
    es   = 7'h7F;
    blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (slot == 2 && snap[2] == 0) blank = 1'b1;
    if (slot == 1 && snap[2] == 0 && snap[1] == 0) blank = 1'b1;
`endif
    if (p >= GRD && !blank) begin
      ea[slot] = 1'b0;
      es = glyph_tab[snap[slot]];
    end
  endtask

  task automatic step(input logic r, input logic u,
                      input logic [3:0] g, input logic [3:0] s,
                      input logic [3:0] b, input logic [3:0] t);
    logic [3:0] ea;
    logic [6:0] es;
    int zeros;
    reset = r; upd = u; ge = g; shi = s; bai = b; tag = t;
    if (!r) begin
      ea = 4'b1111; es = 7'h7F;
    end else begin
      model_out(ea, es);
    end
    @(posedge clk);
    if (!r) begin
      cyc = 0;
      for (int k = 0; k < 4; k++) snap[k] = 4'd0;
    end else begin
      if (u) begin
        snap[0] = g; snap[1] = s; snap[2] = b; snap[3] = t;
      end
      cyc++;
    end
    #1;
    checks++;
    assert (an === ea) else begin
      errors++;
      $error("FAIL an cyc=%0d got=%b exp=%b", cyc, an, ea);
    end
    checks++;
    assert (seg === es) else begin
      errors++;
      $error("FAIL seg cyc=%0d got=%b exp=%b", cyc, seg, es);
    end
    checks++;
    assert (dp === 1'b1) else begin
      errors++;
      $error("FAIL dp cyc=%0d got=%b exp=1", cyc, dp);
    end
    zeros = 0;
    for (int k = 0; k < 4; k++) if (an[k] === 1'b0) zeros++;
    checks++;
    assert (zeros <= 1) else begin
      errors++;
      $error("FAIL an_onehot cyc=%0d got=%b exp=at most one low", cyc, an);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [3:0] g, input logic [3:0] s,
                     input logic [3:0] b, input logic [3:0] t);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, g, s, b, t);
  endtask

  initial begin
    glyph_tab[0] = 7'b1000000; glyph_tab[1] = 7'b1111001;
    glyph_tab[2] = 7'b0100100; glyph_tab[3] = 7'b0110000;
    glyph_tab[4] = 7'b0011001; glyph_tab[5] = 7'b0010010;
    glyph_tab[6] = 7'b0000010; glyph_tab[7] = 7'b1111000;
    glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0010000;
    for (int k = 10; k < 16; k++) glyph_tab[k] = 7'b0111111;
    cyc = 0;
    for (int k = 0; k < 4; k++) snap[k] = 4'd0;

    // Reset for three cycles, then let the zero snapshot scan
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9);
    run(6, 4'd9, 4'd9, 4'd9, 4'd9);

    // Load 5/1/2/3 and watch a full frame
    step(1'b1, 1'b1, 4'd3, 4'd2, 4'd1, 4'd5);
    run(40, 4'd3, 4'd2, 4'd1, 4'd5);

    // Changes without upd must not show
    run(34, 4'd8, 4'd8, 4'd8, 4'd8);

    // Dash codes
    step(1'b1, 1'b1, 4'hA, 4'd4, 4'd6, 4'd12);
    run(34, 4'd0, 4'd0, 4'd0, 4'd0);

    // upd coinciding with tick
    while ((cyc % DIV) != DIV - 1) step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd1, 4'd7, 4'd9, 4'd2);
    run(34, 4'd0, 4'd0, 4'd0, 4'd0);

    // Leading zeros
    step(1'b1, 1'b1, 4'd7, 4'd0, 4'd0, 4'd0);
    run(34, 4'd7, 4'd0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd0, 4'd3, 4'd0, 4'd1);
    run(34, 4'd0, 4'd0, 4'd0, 4'd0);

    // Reset in the middle of the bai slot
    step(1'b1, 1'b1, 4'd4, 4'd5, 4'd6, 4'd7);
    while (!(((cyc / DIV) % 4) == 2 && (cyc % DIV) == 4))
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    run(34, 4'd0, 4'd0, 4'd0, 4'd0);

    // Random digits with occasional snapshots
    for (int n = 0; n < 400; n++) begin
      step(1'b1, ($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
